f2h_axi_burst_writer: RTL
=========================

// Module: f2h_axi_burst_writer
// PURPOSE
//  AXI3 write initiator that drives the HPS FPGA-to-HPS AXI slave (hps_0_f2h_axi_slave_*) from the fabric side.
//  Accepts a 32-bit ADC sample stream and buffers it in a FIFO.
//  Writes it into HPS SDRAM as 16-beat INCR bursts, one burst outstanding at a time.
//  Read channels are not driven by this block; the top level ties them off.
// PARAMETERS
//  BURST_LEN   16       max beats per burst (1..16, AXI3 limit)
//  FIFO_DEPTH  32       sample FIFO depth, power of 2, >= BURST_LEN
//  CNT_W       20       width of the word-count input
//  AXI_ID      8'h00    constant AWID/WID
//  AXI_CACHE   4'b0000  constant AWCACHE
//  AXI_USER    5'b00000 constant AWUSER
// PORTS
//  clk_clk        in   1      single clock, same as hps_0_f2h_axi_clock_clk
//  reset_reset_n  in   1      asynchronous, active-low reset
//  start          in   1      1-cycle pulse, begins a transfer; ignored while busy
//  base_addr      in   32     destination byte address, sampled on start; bits[5:0] forced to 0
//  xfer_words     in   CNT_W  number of 32-bit words to write, sampled on start
//  busy           out  1      transfer in progress
//  done           out  1      1-cycle pulse at end of transfer
//  err            out  1      sticky SLVERR/DECERR seen; cleared on start
//  s_data         in   32     sample data
//  s_valid        in   1      sample valid
//  s_ready        out  1      sample accepted when s_valid && s_ready
//  m_awid,awaddr,awlen,awsize,awburst,awlock,awcache,awprot,awuser,awvalid  out  8,32,4,3,2,2,4,3,5,1
//  m_awready      in   1
//  m_wid,wdata,wstrb,wlast,wvalid  out  8,32,4,1,1
//  m_wready       in   1
//  m_bid,bresp    in   8,2
//  m_bvalid       in   1
//  m_bready       out  1
// BEHAVIOUR
//  Reset: all outputs 0 and FIFO empty; internal counters and addr register 0; FSM in IDLE.
//  FSM states:
//   IDLE : on start, go to WAIT (xfer_words != 0) or FIN (xfer_words == 0); load addr and counters.
//   WAIT : if fifo_count >= blen, where blen = min(BURST_LEN, words_left), go to ADDR.
//   ADDR : awvalid=1 with awlen=blen-1, awsize=3'b010, awburst=2'b01, awlock=0, awprot=0.
//          Hold all AW fields stable until awready, then go to DATA.
//   DATA : wvalid=1, wdata from FIFO head, wstrb=4'hF, wlast on beat blen-1.
//          Pop FIFO on each wvalid&&wready; after the last beat go to RESP.
//   RESP : bready=1; on bvalid, bresp!=2'b00 sets err.
//          Then addr += 4*blen, words_left -= blen; go to FIN if words_left==0, else WAIT.
//   FIN  : done=1 for one cycle, busy=0; go to IDLE.
//  busy is high in every state except IDLE and FIN.
//  s_ready = busy && !fifo_full && (accepted < xfer_words); extra samples are never taken.
//  On a bad bresp the transfer continues; err is only a report.
//  4 KB rule: 64-byte base alignment with <=16x4-byte bursts guarantees no burst crosses 4 KB.
//  Latency: first AWVALID 2 cycles after the FIFO reaches blen. Done comes 1 cycle after the final B handshake.
//  A FIFO push and pop in the same cycle leave fifo_count unchanged.
//  start while busy is ignored, with no effect on err or the counters.
//  Reset mid-burst drops awvalid/wvalid immediately; the team requires the HPS bridge to be reset alongside (h2f reset).
// STRUCTURE
//  Package f2h_axi_pkg: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY/SLVERR/DECERR, and the FSM state enum.
//  Sub-module sample_fifo: synchronous, FIFO_DEPTH x 32, first-word-fall-through.
//   Ports: push, pop, data, count, full, empty.
// TESTING
//  1. base=0x1000_0000, words=16, samples 0..15 streamed.
//     Expect one AW: addr 0x1000_0000, len 15, size 2, burst 1; 16 W beats, wlast on 16th; done 1 cycle after B.
//  2. words=37.
//     Expect 3 bursts: len 15@+0x00, len 15@+0x40, len 4@+0x80; data in order; exactly 37 s_ready handshakes.
//  3. Random awready/wready/bvalid stall (50%), words=64.
//     Expect AW/W fields held stable while valid is low-ready, no dropped or duplicated data, 4 bursts.
//  4. Second burst returns bresp=2'b10.
//     Expect err=1 sticky; transfer still completes with done; next start clears err.
//  5. words=0 start.
//     Expect done on next cycle, no AWVALID; start pulsed while busy changes nothing.
//  6. reset_reset_n low during DATA beat 5.
//     Expect all outputs 0 asynchronously and FIFO empty; a new start works normally.

Source files
------------

// File: rtl/f2h_axi_pkg.sv
// Shared constants and FSM state type for the F2H AXI3 burst writer.
// Imported by the top level and the sample FIFO.
package f2h_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/f2h_axi_burst_writer_fifo.sv
// First-word-fall-through sample FIFO feeding the AXI write data channel.
// Push into a full FIFO or pop from an empty one is ignored.
module sample_fifo
  import f2h_axi_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/f2h_axi_burst_writer.sv
// AXI3 write initiator: streams FIFO-buffered ADC samples into HPS SDRAM
// as INCR bursts through the FPGA-to-HPS bridge, one burst in flight.
module f2h_axi_burst_writer
  import f2h_axi_pkg::*;
#(
  parameter int         BURST_LEN  = 16,
  parameter int         FIFO_DEPTH = 32,
  parameter int         CNT_W      = 20,
  parameter logic [7:0] AXI_ID     = 8'h00,
  parameter logic [3:0] AXI_CACHE  = 4'b0000,
  parameter logic [4:0] AXI_USER   = 5'b00000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] xfer_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_awid,
  output logic [31:0]      m_awaddr,
  output logic [3:0]       m_awlen,
  output logic [2:0]       m_awsize,
  output logic [1:0]       m_awburst,
  output logic [1:0]       m_awlock,
  output logic [3:0]       m_awcache,
  output logic [2:0]       m_awprot,
  output logic [4:0]       m_awuser,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [7:0]       m_wid,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  output logic             m_wlast,
  output logic             m_wvalid,
  input  logic             m_wready,
  input  logic [7:0]       m_bid,
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_left;
  logic [CNT_W-1:0] r_xfer;
  logic [CNT_W-1:0] r_accepted;
  logic [4:0]       r_beat;
  logic             r_err;
  logic             r_fifo_ok;

  logic [4:0]       w_blen;
  logic             w_last;
  logic             w_aw;
  logic             w_w;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_fifo_data;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_unused_bid;

  assign w_unused_bid = &{1'b0, m_bid, w_empty};

  assign w_blen = (r_left >= CNT_W'(BURST_LEN)) ? 5'(BURST_LEN)
                                                : r_left[4:0];
  assign w_last = (r_beat == (w_blen - 5'd1));
  assign w_aw   = (r_state == ST_ADDR);
  assign w_w    = (r_state == ST_DATA);
  assign w_push = s_valid && s_ready;
  assign w_pop  = w_w && m_wready;

  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done    = (r_state == ST_FIN);
  assign err     = r_err;
  assign s_ready = busy && !w_full && (r_accepted < r_xfer);

  assign m_awid    = AXI_ID;
  assign m_awaddr  = w_aw ? r_addr : '0;
  assign m_awlen   = w_aw ? 4'(w_blen - 5'd1) : '0;
  assign m_awsize  = w_aw ? AXI_SIZE_4B : '0;
  assign m_awburst = w_aw ? AXI_BURST_INCR : '0;
  assign m_awlock  = '0;
  assign m_awcache = AXI_CACHE;
  assign m_awprot  = '0;
  assign m_awuser  = AXI_USER;
  assign m_awvalid = w_aw;

  assign m_wid    = AXI_ID;
  assign m_wdata  = w_w ? w_fifo_data : '0;
  assign m_wstrb  = w_w ? 4'hF : 4'h0;
  assign m_wlast  = w_w && w_last;
  assign m_wvalid = w_w;
  assign m_bready = (r_state == ST_RESP);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (s_data),
    .o_data  (w_fifo_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)
                 w_next = (xfer_words == '0) ? ST_FIN : ST_WAIT;
      ST_WAIT: if (r_fifo_ok) w_next = ST_ADDR;
      ST_ADDR: if (m_awready) w_next = ST_DATA;
      ST_DATA: if (m_wready && w_last) w_next = ST_RESP;
      ST_RESP: if (m_bvalid)
                 w_next = (r_left == CNT_W'(w_blen)) ? ST_FIN
                                                     : ST_WAIT;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Fill check is registered and only armed inside WAIT, so a
  // stale blen from another state can never launch a burst early.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_xfer     <= '0;
      r_accepted <= '0;
      r_beat     <= '0;
      r_err      <= 1'b0;
      r_fifo_ok  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_fifo_ok <= (r_state == ST_WAIT) &&
                   (w_count >= CW'(w_blen));
      if (w_push) r_accepted <= r_accepted + 1'b1;
      if (r_state == ST_IDLE && start) begin
        r_addr     <= {base_addr[31:6], 6'd0};
        r_left     <= xfer_words;
        r_xfer     <= xfer_words;
        r_accepted <= '0;
        r_err      <= 1'b0;
      end
      if (w_pop)          r_beat <= r_beat + 5'd1;
      else if (!w_w)      r_beat <= '0;
      if (r_state == ST_RESP && m_bvalid) begin
        if (m_bresp != AXI_RESP_OKAY) r_err <= 1'b1;
        r_addr <= r_addr + 32'({w_blen, 2'b00});
        r_left <= r_left - CNT_W'(w_blen);
      end
    end
  end

endmodule
